// File: rtl/vc_fifo_bank_if.sv
// Handshake and status bundle for vc_fifo_bank. Channel i occupies slice [i*W +: W] of every bus.
// The producer/arbiter side connects through master; the FIFO bank connects through slave.
interface vc_fifo_bank_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_VC     = 2
);
  logic [NUM_VC-1:0]            wr_enable;
  logic [NUM_VC*DATA_WIDTH-1:0] data_in;
  logic [NUM_VC-1:0]            rd_enable;
  logic [NUM_VC*ADDR_WIDTH-1:0] umbral_low;
  logic [NUM_VC*ADDR_WIDTH-1:0] umbral_high;
  logic [NUM_VC*DATA_WIDTH-1:0] data_out;
  logic [NUM_VC-1:0]            valid_out;
  logic [NUM_VC*DATA_WIDTH-1:0] head;
  logic [NUM_VC-1:0]            full;
  logic [NUM_VC-1:0]            empty;
  logic [NUM_VC-1:0]            almost_full;
  logic [NUM_VC-1:0]            almost_empty;
  logic [NUM_VC-1:0]            err_overflow;
  logic [NUM_VC-1:0]            err_underflow;

  modport master (
    output wr_enable, data_in, rd_enable, umbral_low, umbral_high,
    input  data_out, valid_out, head, full, empty, almost_full, almost_empty,
           err_overflow, err_underflow
  );

  modport slave (
    input  wr_enable, data_in, rd_enable, umbral_low, umbral_high,
    output data_out, valid_out, head, full, empty, almost_full, almost_empty,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent circular FIFOs with registered pop port, show-ahead head and sticky errors.
// Optional macro VC_FIFO_BYPASS_EN: a push+pop on an empty channel passes data_in straight to data_out.
module vc_fifo_bank #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_VC     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  vc_fifo_bank_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic clear;
  assign clear = !reset || !init;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

    logic                  wr, rd, is_full, is_empty, push_ok, pop_ok, bypass;
    logic [DATA_WIDTH-1:0] din;
    logic [ADDR_WIDTH-1:0] ul, uh;

    assign wr  = bus.wr_enable[v];
    assign rd  = bus.rd_enable[v];
    assign din = bus.data_in[v*DATA_WIDTH +: DATA_WIDTH];
    assign ul  = bus.umbral_low[v*ADDR_WIDTH +: ADDR_WIDTH];
    assign uh  = bus.umbral_high[v*ADDR_WIDTH +: ADDR_WIDTH];

    assign is_full  = (cnt_q == CNT_FULL);
    assign is_empty = (cnt_q == '0);
    assign pop_ok   = rd && !is_empty;
`ifdef VC_FIFO_BYPASS_EN
    assign bypass   = wr && rd && is_empty;
`else
    assign bypass   = 1'b0;
`endif
    // A pop frees the slot on a full channel, so the push may proceed in the same cycle.
    assign push_ok  = wr && (!is_full || pop_ok) && !bypass;

    always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      data_out_d  = '0;
      valid_out_d = 1'b0;
      err_ovf_d   = err_ovf_q || (wr && is_full && !pop_ok);
      err_udf_d   = err_udf_q || (rd && is_empty && !bypass);

      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        data_out_d  = mem_q[rd_ptr_q];
        valid_out_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + 1'b1;
      end else if (bypass) begin
        data_out_d  = din;
        valid_out_d = 1'b1;
      end

      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase

      // NOTE: the synchronous clear lives in the next-state logic, so the flops below
      // stay plain non-blocking registers with no reset branch; clear wins over every input.
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        cnt_d       = '0;
        data_out_d  = '0;
        valid_out_d = 1'b0;
        err_ovf_d   = 1'b0;
        err_udf_d   = 1'b0;
      end
    end

    // NOTE: the storage words are cleared along with the pointers, which keeps them in
    // flops rather than a RAM macro; that is acceptable at this depth and width.
    always_ff @(posedge clk) begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
    end

    assign bus.data_out[v*DATA_WIDTH +: DATA_WIDTH] = data_out_q;
    assign bus.head[v*DATA_WIDTH +: DATA_WIDTH]     = is_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.valid_out[v]     = valid_out_q;
    assign bus.err_overflow[v]  = err_ovf_q;
    assign bus.err_underflow[v] = err_udf_q;

    // Status is forced to the cleared pattern while a clear is being applied.
    assign bus.full[v]         = !clear && is_full;
    assign bus.empty[v]        = clear || is_empty;
    assign bus.almost_full[v]  = !clear && !is_full && (cnt_q >= (CNT_FULL - {1'b0, uh}));
    assign bus.almost_empty[v] = !clear && !is_empty && (cnt_q <= {1'b0, ul});
  end
endmodule
